serial_sample_player: RTL and testbench

Playback and scoring engine for the serial genetic-circuit evaluator. It reads the per-byte sample tables (input sequences, expected outputs, valid masks) that the sample loader fills, and streams each input byte bit-serially into the candidate circuit. It samples the circuit's serial output after every step and counts matching and mismatching bits wherever the valid mask is set. The resulting counts feed the fitness logic.

---
 rtl/serial_sample_player_if.sv | 76 +++++++
 rtl/serial_sample_player.sv | 177 +++++++++++++++++
 tb/tb_serial_sample_player.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/serial_sample_player_if.sv
//------------------------------------------------------------------------------
// serial_sample_player_if
//
// Bundles the control, sample-table, candidate-circuit and scoring signals of
// the serial sample player. Clock and reset stay outside as plain ports.
//
//   slave  : the player itself (takes the i* signals, drives the o* signals)
//   master : the environment (controller, sample loader, candidate circuit)
//
// Signals:
//   iStart / iAbort          pass control
//   iInputSequences          input byte per sample slot
//   iExpectedOutputs         expected output bits per slot
//   iValidOutputs            1 = bit is scored, 0 = don't-care
//   oCircuitReset            one-cycle reset pulse to the candidate circuit
//   oCircuitInput            serial data bit into the candidate circuit
//   oCircuitStep             one-cycle clock enable to the candidate circuit
//   iCircuitOutput           candidate circuit serial output
//   oBusy / oDone            status
//   oMatchCount/oErrorCount  scored-bit counters
//   oPerfect                 no errors and at least one match at pass end
//------------------------------------------------------------------------------
`timescale 1ns/1ps

interface serial_sample_player_if #(
    parameter int NUM_SAMPLES = 23
);
    logic                         iStart;
    logic                         iAbort;
    logic [NUM_SAMPLES:0][7:0]    iInputSequences;
    logic [NUM_SAMPLES:0][7:0]    iExpectedOutputs;
    logic [NUM_SAMPLES:0][7:0]    iValidOutputs;
    logic                         oCircuitReset;
    logic                         oCircuitInput;
    logic                         oCircuitStep;
    logic                         iCircuitOutput;
    logic                         oBusy;
    logic                         oDone;
    logic [15:0]                  oMatchCount;
    logic [15:0]                  oErrorCount;
    logic                         oPerfect;

    modport slave (
        input  iStart,
        input  iAbort,
        input  iInputSequences,
        input  iExpectedOutputs,
        input  iValidOutputs,
        output oCircuitReset,
        output oCircuitInput,
        output oCircuitStep,
        input  iCircuitOutput,
        output oBusy,
        output oDone,
        output oMatchCount,
        output oErrorCount,
        output oPerfect
    );

    modport master (
        output iStart,
        output iAbort,
        output iInputSequences,
        output iExpectedOutputs,
        output iValidOutputs,
        input  oCircuitReset,
        input  oCircuitInput,
        input  oCircuitStep,
        output iCircuitOutput,
        input  oBusy,
        input  oDone,
        input  oMatchCount,
        input  oErrorCount,
        input  oPerfect
    );
endinterface

// File: rtl/serial_sample_player.sv
//------------------------------------------------------------------------------
// serial_sample_player
//
// Playback and scoring engine. For every sample byte it pulses the candidate
// circuit reset, then streams the byte LSB first, one step per bit, and
// compares the circuit output seen after each step against the expected bit
// wherever the valid mask is set.
//
// Ports:
//   iClock    system clock (posedge)
//   iReset_n  asynchronous active-low reset
//   bus       serial_sample_player_if.slave (control, tables, circuit, scores)
//
// Every output is a flop. Outputs that belong to a state are computed from the
// next state, so they are high during exactly the cycle spent in that state.
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module serial_sample_player #(
    parameter int NUM_SAMPLES = 23
) (
    input  logic                      iClock,
    input  logic                      iReset_n,
    serial_sample_player_if.slave     bus
);

    localparam int IDX_W = (NUM_SAMPLES > 0) ? $clog2(NUM_SAMPLES + 1) : 1;
    localparam logic [IDX_W-1:0] LAST_BYTE = IDX_W'(NUM_SAMPLES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_DRIVE,
        S_SAMPLE,
        S_DONE
    } state_t;

    state_t            state_q,      state_d;
    logic [IDX_W-1:0]  byte_q,       byte_d;
    logic [2:0]        bit_q,        bit_d;
    logic [7:0]        in_snap_q,    in_snap_d;
    logic [7:0]        exp_snap_q,   exp_snap_d;
    logic [7:0]        val_snap_q,   val_snap_d;
    logic [15:0]       match_q,      match_d;
    logic [15:0]       error_q,      error_d;
    logic              perfect_q,    perfect_d;
    logic              circ_reset_q, circ_reset_d;
    logic              circ_input_q, circ_input_d;
    logic              circ_step_q,  circ_step_d;
    logic              busy_q,       busy_d;
    logic              done_q,       done_d;

    always_comb begin
        state_d    = state_q;
        byte_d     = byte_q;
        bit_d      = bit_q;
        in_snap_d  = in_snap_q;
        exp_snap_d = exp_snap_q;
        val_snap_d = val_snap_q;
        match_d    = match_q;
        error_d    = error_q;
        perfect_d  = perfect_q;

        case (state_q)
            S_IDLE: begin
                if (bus.iStart) begin
                    match_d   = 16'd0;
                    error_d   = 16'd0;
                    perfect_d = 1'b0;
                    byte_d    = '0;
                    state_d   = S_LOAD;
                end
            end
            S_LOAD: begin
                // The only place table bytes are read; later edits to this
                // slot cannot disturb the byte being played.
                in_snap_d  = bus.iInputSequences[byte_q];
                exp_snap_d = bus.iExpectedOutputs[byte_q];
                val_snap_d = bus.iValidOutputs[byte_q];
                bit_d      = 3'd0;
                state_d    = S_DRIVE;
            end
            S_DRIVE: begin
                state_d = S_SAMPLE;
            end
            S_SAMPLE: begin
                if (val_snap_q[bit_q]) begin
                    if (bus.iCircuitOutput == exp_snap_q[bit_q]) begin
                        match_d = (match_q == 16'hFFFF) ? match_q : match_q + 16'd1;
                    end else begin
                        error_d = (error_q == 16'hFFFF) ? error_q : error_q + 16'd1;
                    end
                end
                if (bit_q != 3'd7) begin
                    bit_d   = bit_q + 3'd1;
                    state_d = S_DRIVE;
                end else if (byte_q != LAST_BYTE) begin
                    byte_d  = byte_q + 1'b1;
                    state_d = S_LOAD;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                perfect_d = (error_q == 16'd0) && (match_q != 16'd0);
                state_d   = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort overrides everything above, including a bit being scored on
        // this very edge and the end-of-pass verdict.
        if (bus.iAbort && (state_q != S_IDLE)) begin
            state_d    = S_IDLE;
            byte_d     = byte_q;
            bit_d      = bit_q;
            in_snap_d  = in_snap_q;
            exp_snap_d = exp_snap_q;
            val_snap_d = val_snap_q;
            match_d    = match_q;
            error_d    = error_q;
            perfect_d  = perfect_q;
        end

        circ_reset_d = (state_d == S_LOAD);
        circ_step_d  = (state_d == S_DRIVE);
        circ_input_d = ((state_d == S_DRIVE) || (state_d == S_SAMPLE)) ? in_snap_d[bit_d] : 1'b0;
        busy_d       = (state_d != S_IDLE);
        done_d       = (state_d == S_DONE);
    end

    always_ff @(posedge iClock or negedge iReset_n) begin
        if (!iReset_n) begin
            state_q      <= S_IDLE;
            byte_q       <= '0;
            bit_q        <= 3'd0;
            in_snap_q    <= 8'd0;
            exp_snap_q   <= 8'd0;
            val_snap_q   <= 8'd0;
            match_q      <= 16'd0;
            error_q      <= 16'd0;
            perfect_q    <= 1'b0;
            circ_reset_q <= 1'b0;
            circ_input_q <= 1'b0;
            circ_step_q  <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            byte_q       <= byte_d;
            bit_q        <= bit_d;
            in_snap_q    <= in_snap_d;
            exp_snap_q   <= exp_snap_d;
            val_snap_q   <= val_snap_d;
            match_q      <= match_d;
            error_q      <= error_d;
            perfect_q    <= perfect_d;
            circ_reset_q <= circ_reset_d;
            circ_input_q <= circ_input_d;
            circ_step_q  <= circ_step_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign bus.oCircuitReset = circ_reset_q;
    assign bus.oCircuitInput = circ_input_q;
    assign bus.oCircuitStep  = circ_step_q;
    assign bus.oBusy         = busy_q;
    assign bus.oDone         = done_q;
    assign bus.oMatchCount   = match_q;
    assign bus.oErrorCount   = error_q;
    assign bus.oPerfect      = perfect_q;

endmodule

// File: tb/tb_serial_sample_player.sv
`timescale 1ns/1ps

module tb_serial_sample_player;

    localparam int NS     = 23;
    localparam int NBYTES = NS + 1;
    localparam int DONE_C = 1 + 17 * NBYTES;   // 409

    logic iClock;
    logic iReset_n;

    int tests_run;
    int tests_failed;

    // Sample tables and per-bit circuit corruption pattern, owned by the bench.
    logic [7:0] in_tbl   [0:NS];
    logic [7:0] exp_tbl  [0:NS];
    logic [7:0] val_tbl  [0:NS];
    logic [7:0] flip_tbl [0:NS];

    serial_sample_player_if #(.NUM_SAMPLES(NS)) bus ();

    serial_sample_player #(.NUM_SAMPLES(NS)) dut (
        .iClock   (iClock),
        .iReset_n (iReset_n),
        .bus      (bus)
    );

    initial iClock = 1'b0;
    always #5 iClock = ~iClock;

    // Candidate circuit: output = registered input XOR flip_tbl[byte][bit].
    // The byte index follows the circuit reset pulses since the last start.
    logic circ_out;
    int   nbyte, cbyte, cbit;
    always @(posedge iClock or negedge iReset_n) begin
        if (!iReset_n) begin
            circ_out <= 1'b0;
            nbyte    <= 0;
            cbyte    <= 0;
            cbit     <= 0;
        end else begin
            if (bus.iStart && !bus.oBusy) nbyte <= 0;
            if (bus.oCircuitReset) begin
                circ_out <= 1'b0;
                cbyte    <= nbyte;
                nbyte    <= nbyte + 1;
                cbit     <= 0;
            end else if (bus.oCircuitStep) begin
                circ_out <= bus.oCircuitInput ^
                            ((cbyte <= NS && cbit < 8) ? flip_tbl[cbyte][cbit] : 1'b0);
                cbit     <= cbit + 1;
            end
        end
    end
    assign bus.iCircuitOutput = circ_out;

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load_tables();
        for (int j = 0; j <= NS; j++) begin
            bus.iInputSequences[j]  = in_tbl[j];
            bus.iExpectedOutputs[j] = exp_tbl[j];
            bus.iValidOutputs[j]    = val_tbl[j];
        end
    endtask

    // Reference scoring: bit b of byte j is sampled in cycle 3+17j+2b and is
    // counted only if that sample cycle ends before the cycle holding an abort.
    task automatic ref_counts(input int limit, output int m, output int e);
        m = 0;
        e = 0;
        for (int j = 0; j <= NS; j++) begin
            for (int b = 0; b < 8; b++) begin
                if ((3 + 17 * j + 2 * b) < limit && val_tbl[j][b]) begin
                    if ((in_tbl[j][b] ^ flip_tbl[j][b]) == exp_tbl[j][b]) m++;
                    else e++;
                end
            end
        end
    endtask

    logic [511:0] last_in_tr;

    // Called at a falling edge; that edge is cycle 0 of the pass.
    task automatic run_pass(input string name, input int ncyc, input int abort_at, input int stray_at);
        logic [511:0] rst_tr, stp_tr, in_tr, bsy_tr, dn_tr;
        logic [511:0] rst_ex, stp_ex, in_ex, bsy_ex, dn_ex;
        int last_c, m, e, off, j, b;
        logic exp_perfect;
        rst_tr = '0; stp_tr = '0; in_tr = '0; bsy_tr = '0; dn_tr = '0;
        rst_ex = '0; stp_ex = '0; in_ex = '0; bsy_ex = '0; dn_ex = '0;
        bus.iStart = 1'b1;
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge iClock);
            rst_tr[c] = bus.oCircuitReset;
            stp_tr[c] = bus.oCircuitStep;
            in_tr[c]  = bus.oCircuitInput;
            bsy_tr[c] = bus.oBusy;
            dn_tr[c]  = bus.oDone;
            bus.iStart = (c == stray_at);
            bus.iAbort = (c == abort_at);
        end
        last_c = (abort_at > 0) ? abort_at : DONE_C;
        for (int c = 1; c <= ncyc; c++) begin
            if (c <= last_c) begin
                bsy_ex[c] = 1'b1;
                if (c == DONE_C) begin
                    dn_ex[c] = 1'b1;
                end else begin
                    off = (c - 1) % 17;
                    j   = (c - 1) / 17;
                    if (off == 0) begin
                        rst_ex[c] = 1'b1;
                    end else begin
                        b = (off - 1) / 2;
                        if (((off - 1) % 2) == 0) stp_ex[c] = 1'b1;
                        in_ex[c] = in_tbl[j][b];
                    end
                end
            end
        end
        chk({name, "_reset_trace"}, rst_tr, rst_ex);
        chk({name, "_step_trace"},  stp_tr, stp_ex);
        chk({name, "_input_trace"}, in_tr,  in_ex);
        chk({name, "_busy_trace"},  bsy_tr, bsy_ex);
        chk({name, "_done_trace"},  dn_tr,  dn_ex);
        ref_counts((abort_at > 0) ? abort_at : 32'h3fff_ffff, m, e);
        exp_perfect = (abort_at > 0) ? 1'b0 : ((e == 0) && (m > 0));
        chk({name, "_match"},   512'(bus.oMatchCount), 512'(m));
        chk({name, "_error"},   512'(bus.oErrorCount), 512'(e));
        chk({name, "_perfect"}, 512'(bus.oPerfect),    512'(exp_perfect));
        last_in_tr = in_tr;
        $display("[TB] pass %s: cycles=%0d abort_at=%0d match=%0d error=%0d perfect=%0b (model %0d/%0d/%0b)",
                 name, ncyc, abort_at, bus.oMatchCount, bus.oErrorCount, bus.oPerfect, m, e, exp_perfect);
    endtask

    task automatic randomize_tables(input logic use_flip);
        for (int j = 0; j <= NS; j++) begin
            in_tbl[j]   = 8'($urandom);
            exp_tbl[j]  = 8'($urandom);
            val_tbl[j]  = 8'($urandom);
            flip_tbl[j] = use_flip ? 8'($urandom) : 8'h00;
        end
    endtask

    logic [511:0] busy_seen;

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        iReset_n     = 1'b0;
        bus.iStart   = 1'b0;
        bus.iAbort   = 1'b0;
        for (int j = 0; j <= NS; j++) begin
            in_tbl[j] = 8'h00; exp_tbl[j] = 8'h00; val_tbl[j] = 8'h00; flip_tbl[j] = 8'h00;
        end
        load_tables();
        repeat (3) @(negedge iClock);
        chk("reset_outputs", 512'({bus.oCircuitReset, bus.oCircuitInput, bus.oCircuitStep, bus.oBusy,
                                   bus.oDone, bus.oPerfect, bus.oMatchCount, bus.oErrorCount}), 512'(0));
        iReset_n = 1'b1;
        repeat (2) @(negedge iClock);

        // Identity circuit, everything expected and scored; byte 0 = 0x01.
        randomize_tables(1'b0);
        in_tbl[0] = 8'h01;
        for (int j = 0; j <= NS; j++) begin exp_tbl[j] = in_tbl[j]; val_tbl[j] = 8'hFF; end
        load_tables();
        run_pass("identity", DONE_C + 3, 0, 0);
        chk("identity_match_192", 512'(bus.oMatchCount), 512'(192));
        chk("identity_error_0",   512'(bus.oErrorCount), 512'(0));
        chk("identity_perfect",   512'(bus.oPerfect),    512'(1));
        chk("bit_order_byte0", 512'({last_in_tr[5], last_in_tr[4], last_in_tr[3], last_in_tr[2]}), 512'(4'b0011));

        // Byte 5 expected inverted.
        exp_tbl[5] = ~in_tbl[5];
        load_tables();
        run_pass("byte5_inverted", DONE_C + 3, 0, 0);
        chk("byte5_error_8",   512'(bus.oErrorCount), 512'(8));
        chk("byte5_match_184", 512'(bus.oMatchCount), 512'(184));
        chk("byte5_perfect_0", 512'(bus.oPerfect),    512'(0));

        // Lower nibble scored only, upper nibbles wrong.
        for (int j = 0; j <= NS; j++) begin exp_tbl[j] = in_tbl[j] ^ 8'hF0; val_tbl[j] = 8'h0F; end
        load_tables();
        run_pass("nibble_mask", DONE_C + 3, 0, 0);
        chk("nibble_match_96", 512'(bus.oMatchCount), 512'(96));
        chk("nibble_error_0",  512'(bus.oErrorCount), 512'(0));

        // Random tables and a noisy circuit; iStart during DONE must be ignored.
        randomize_tables(1'b1);
        load_tables();
        run_pass("random", DONE_C + 3, 0, DONE_C);

        // Stray start at 50, abort at 100 (a SAMPLE cycle), restart at 101.
        randomize_tables(1'b1);
        load_tables();
        run_pass("abort", 101, 100, 50);
        repeat (0) @(negedge iClock);
        run_pass("after_abort", DONE_C + 3, 0, 0);

        // Asynchronous reset in the middle of byte 3.
        randomize_tables(1'b1);
        load_tables();
        bus.iStart = 1'b1;
        @(negedge iClock);
        bus.iStart = 1'b0;
        repeat (55) @(negedge iClock);
        #2 iReset_n = 1'b0;
        #1;
        chk("midpass_reset_outputs", 512'({bus.oCircuitReset, bus.oCircuitInput, bus.oCircuitStep, bus.oBusy,
                                           bus.oDone, bus.oPerfect, bus.oMatchCount, bus.oErrorCount}), 512'(0));
        @(negedge iClock);
        iReset_n = 1'b1;
        busy_seen = '0;
        for (int c = 0; c < 20; c++) begin
            @(negedge iClock);
            busy_seen[c] = bus.oBusy | bus.oDone;
        end
        chk("post_reset_idle", busy_seen, 512'(0));
        run_pass("after_reset", DONE_C + 3, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
